bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter DLEN, default 32, data word width in bits.
REQ-002 Parameter HLEN, default 5, address width in bits; depth is 2^HLEN words.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester request valid; bit i is requester i.
REQ-006 req_we  input  2  per-requester op select: 1 write, 0 read.
REQ-007 req_addr  input  2*HLEN  per-requester address; requester i uses slice [i*HLEN +: HLEN].
REQ-008 req_wdata  input  2*DLEN  per-requester write data; requester i uses slice [i*DLEN +: DLEN].
REQ-009 req_ready  output  2  per-requester grant; request accepted when valid and ready are both high.
REQ-010 rsp_valid  output  2  per-requester read-data valid, one-hot or zero.
REQ-011 rsp_data  output  DLEN  read data, qualified by rsp_valid.
REQ-012 bram_wen  output  1  RAM write enable.
REQ-013 bram_waddr  output  HLEN  RAM write address.
REQ-014 bram_din  output  DLEN  RAM write data.
REQ-015 bram_raddr  output  HLEN  RAM read address.
REQ-016 bram_dout  input  DLEN  RAM registered read data, valid one cycle after raddr.
REQ-017 conflict_cnt  output  16  saturating count of contended arbitration cycles.

Function
REQ-018 Write and read ports are arbitrated independently; a write from one requester and a read from the other are both granted in the same cycle.
REQ-019 Write candidates = req_valid & req_we; read candidates = req_valid & ~req_we.
REQ-020 Single candidate on a port is granted; two candidates are resolved per REQ-036/037.
REQ-021 req_ready is combinational from the current-cycle candidates; a requester not granted sees ready low and holds its request.
REQ-022 Granted write: bram_wen=1, bram_waddr and bram_din from the winner, same cycle; otherwise bram_wen=0, bram_waddr=0, bram_din=0.
REQ-023 Granted read: bram_raddr from the winner, same cycle; otherwise bram_raddr=0.
REQ-024 Read latency is exactly 1 cycle: a pending register captures (valid, winner id) at grant; next cycle rsp_valid[id]=1 and rsp_data=bram_dout.
REQ-025 rsp_data = bram_dout combinationally at all times; meaningful only while rsp_valid is nonzero.
REQ-026 Back-to-back reads by the same requester are accepted every cycle with one response per cycle, in order.
REQ-027 Read and write to the same address in the same cycle: the read returns the pre-write contents (read-before-write).
REQ-028 conflict_cnt increments by 1 in each cycle in which either port has two candidates (both ports contended still counts 1); it holds at 16'hFFFF.

Reset
REQ-029 While reset is high: req_ready=0, bram_wen=0, pending-read valid cleared, rsp_valid=0.
REQ-030 After reset: both priority pointers select requester 0, and conflict_cnt=0.
REQ-031 A read granted in the cycle before reset asserts produces no response; the pending read is dropped.
REQ-032 The first grant is possible in the first cycle with reset low.

Configuration
REQ-033 Macro BRAM_ARB_RR_EN selects the arbitration policy.
REQ-034 With BRAM_ARB_RR_EN defined: a separate round-robin pointer is kept for each port.
REQ-035 With BRAM_ARB_RR_EN defined: the pointer moves to the losing requester after every contended grant on that port and is unchanged otherwise.
REQ-036 With BRAM_ARB_RR_EN defined: a contended port is granted to the requester named by its pointer.
REQ-037 Without BRAM_ARB_RR_EN: fixed priority; requester 0 always wins a contended port and no pointer state exists.

Verification
REQ-038 Single write, then read: r0 write addr 3 data 0xA5A5A5A5; next cycle r0 read addr 3 -> rsp_valid=2'b01 with rsp_data=0xA5A5A5A5 one cycle after the read grant.
REQ-039 Mixed ops: r0 write addr 1 and r1 read addr 2 in the same cycle -> both ready=1; next cycle rsp_valid=2'b10; conflict_cnt unchanged.
REQ-040 Read contention: both requesters read continuously for 4 cycles -> with RR, grants alternate r0,r1,r0,r1; without RR, r0 is granted all 4; conflict_cnt=4.
REQ-041 Read-before-write: addr 5 holds 0x1; r0 writes 0x2 to addr 5 while r1 reads addr 5 -> r1 receives 0x1; a later read of addr 5 returns 0x2.
REQ-042 Reset during read: r1 read granted, reset asserted the next cycle -> rsp_valid stays 0; pointers and conflict_cnt return to reset values.
REQ-043 Counter saturation: force 65540 contended cycles -> conflict_cnt=16'hFFFF and holds.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: requester handshake and BRAM port bundle for bram_port_arbiter.
// master = requesters plus RAM (environment side), slave = arbiter side.
interface bram_port_arbiter_if #(
    parameter int DLEN = 32,
    parameter int HLEN = 5
);
    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [2*HLEN-1:0] req_addr;
    logic [2*DLEN-1:0] req_wdata;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [DLEN-1:0]   rsp_data;
    logic              bram_wen;
    logic [HLEN-1:0]   bram_waddr;
    logic [DLEN-1:0]   bram_din;
    logic [HLEN-1:0]   bram_raddr;
    logic [DLEN-1:0]   bram_dout;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, bram_dout,
        input  req_ready, rsp_valid, rsp_data, bram_wen, bram_waddr, bram_din, bram_raddr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, bram_dout,
        output req_ready, rsp_valid, rsp_data, bram_wen, bram_waddr, bram_din, bram_raddr
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: two requesters sharing a simple dual-port BRAM.
// Write and read ports are arbitrated independently; read data returns one cycle
// after the read grant. Define BRAM_ARB_RR_EN for per-port round-robin arbitration;
// without it requester 0 always wins a contended port.
module bram_port_arbiter #(
    parameter int DLEN = 32,
    parameter int HLEN = 5
) (
    input  logic                clk,
    input  logic                reset,
    bram_port_arbiter_if.slave  bus,
    output logic [15:0]         conflict_cnt
);
    logic [1:0]  wr_cand;
    logic [1:0]  rd_cand;
    logic        wr_contend;
    logic        rd_contend;
    logic        wr_pri;
    logic        rd_pri;
    logic        wr_win;
    logic        rd_win;
    logic        wr_go;
    logic        rd_go;
    logic        rd_pend_q;
    logic        rd_pend_d;
    logic        rd_pend_id_q;
    logic        rd_pend_id_d;
    logic [15:0] conflict_cnt_q;
    logic [15:0] conflict_cnt_d;

`ifdef BRAM_ARB_RR_EN
    logic wr_ptr_q;
    logic wr_ptr_d;
    logic rd_ptr_q;
    logic rd_ptr_d;

    // Each port's pointer hands priority to the loser after a contended grant
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_go && wr_contend) wr_ptr_d = ~wr_win;
        if (rd_go && rd_contend) rd_ptr_d = ~rd_win;
    end

    // Pointer registers, both favour requester 0 out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign wr_pri = wr_ptr_q;
    assign rd_pri = rd_ptr_q;
`else
    assign wr_pri = 1'b0;
    assign rd_pri = 1'b0;
`endif

    // Candidate split and per-port winner selection
    always_comb begin
        wr_cand    = bus.req_valid & bus.req_we;
        rd_cand    = bus.req_valid & ~bus.req_we;
        wr_contend = &wr_cand;
        rd_contend = &rd_cand;
        wr_win     = wr_contend ? wr_pri : wr_cand[1];
        rd_win     = rd_contend ? rd_pri : rd_cand[1];
        wr_go      = (|wr_cand) && !reset;
        rd_go      = (|rd_cand) && !reset;
    end

    // Grants, RAM port drive and response qualification
    always_comb begin
        bus.req_ready  = '0;
        bus.bram_wen   = wr_go;
        bus.bram_waddr = '0;
        bus.bram_din   = '0;
        bus.bram_raddr = '0;
        bus.rsp_valid  = '0;
        bus.rsp_data   = bus.bram_dout;
        if (wr_go) begin
            bus.req_ready[wr_win] = 1'b1;
            bus.bram_waddr = wr_win ? bus.req_addr[2*HLEN-1:HLEN] : bus.req_addr[HLEN-1:0];
            bus.bram_din   = wr_win ? bus.req_wdata[2*DLEN-1:DLEN] : bus.req_wdata[DLEN-1:0];
        end
        if (rd_go) begin
            bus.req_ready[rd_win] = 1'b1;
            bus.bram_raddr = rd_win ? bus.req_addr[2*HLEN-1:HLEN] : bus.req_addr[HLEN-1:0];
        end
        // Masking with reset drops a read granted just before reset asserted
        if (rd_pend_q && !reset) bus.rsp_valid[rd_pend_id_q] = 1'b1;
    end

    // Next-state for pending read and saturating contention counter
    always_comb begin
        rd_pend_d      = rd_go;
        rd_pend_id_d   = rd_win;
        conflict_cnt_d = conflict_cnt_q;
        if (!reset && (wr_contend || rd_contend) && (conflict_cnt_q != '1))
            conflict_cnt_d = conflict_cnt_q + 16'd1;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q      <= 1'b0;
            rd_pend_id_q   <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            rd_pend_q      <= rd_pend_d;
            rd_pend_id_q   <= rd_pend_id_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: scenario tasks for bram_port_arbiter with a read-response
// scoreboard and a behavioural registered-read BRAM. Build with BRAM_ARB_RR_EN to
// exercise the round-robin policy.
module tb_bram_port_arbiter;
    localparam int DLEN = 32;
    localparam int HLEN = 5;
`ifdef BRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic            id;
        logic [DLEN-1:0] data;
        int              due;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] conflict_cnt;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int unsigned cnt_exp = 0;
    logic [DLEN-1:0] exp7 = '0;
    rsp_t        sb[$];
    logic [DLEN-1:0] mem [0:(1<<HLEN)-1];

    bram_port_arbiter_if #(.DLEN(DLEN), .HLEN(HLEN)) bus ();

    bram_port_arbiter #(.DLEN(DLEN), .HLEN(HLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read RAM: read returns contents before a same-cycle write
    always @(posedge clk) begin
        if (bus.bram_wen) mem[bus.bram_waddr] <= bus.bram_din;
        bus.bram_dout <= mem[bus.bram_raddr];
    end

    // Scoreboard: compare responses due this cycle, otherwise expect silence
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
            tests++; fails++;
            $display("FAIL rsp_missed: got none, required id %0d data %h", sb[0].id, sb[0].data);
            void'(sb.pop_front());
        end
        tests++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            if (bus.rsp_valid !== (sb[0].id ? 2'b10 : 2'b01) || bus.rsp_data !== sb[0].data) begin
                fails++;
                $display("FAIL rsp: got valid %b data %h, required id %0d data %h",
                         bus.rsp_valid, bus.rsp_data, sb[0].id, sb[0].data);
            end
            void'(sb.pop_front());
        end else if (bus.rsp_valid !== 2'b00) begin
            fails++;
            $display("FAIL rsp_idle: got valid %b, required 00", bus.rsp_valid);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic rst, input logic [1:0] v, input logic [1:0] we,
                         input logic [HLEN-1:0] a0, input logic [HLEN-1:0] a1,
                         input logic [DLEN-1:0] d0, input logic [DLEN-1:0] d1);
        @(posedge clk); #1;
        reset         = rst;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = {a1, a0};
        bus.req_wdata = {d1, d0};
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
    endtask

    task automatic expect_rsp(input logic id, input logic [DLEN-1:0] d);
        sb.push_back('{id: id, data: d, due: cyc + 1});
    endtask

    task automatic test_reset();
        drive(1'b1, 2'b11, 2'b01, 5'd4, 5'd6, 32'hDEAD_BEEF, '0);
        tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL rst_ready: got %b, required 00", bus.req_ready); end
        tests++; if (bus.bram_wen !== 1'b0) begin fails++; $display("FAIL rst_wen: got %b, required 0", bus.bram_wen); end
        tests++; if (bus.bram_raddr !== 5'd0) begin fails++; $display("FAIL rst_raddr: got %0d, required 0", bus.bram_raddr); end
        drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
        tests++; if (conflict_cnt !== 16'd0) begin fails++; $display("FAIL rst_cnt: got %0d, required 0", conflict_cnt); end
        cnt_exp = 0;
    endtask

    task automatic test_write_read();
        drive(1'b0, 2'b01, 2'b01, 5'd3, '0, 32'hA5A5_A5A5, '0);
        tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL wr_first_ready: got %b, required 01", bus.req_ready); end
        tests++; if (bus.bram_wen !== 1'b1 || bus.bram_waddr !== 5'd3 || bus.bram_din !== 32'hA5A5_A5A5) begin
            fails++; $display("FAIL wr_port: got wen %b addr %0d din %h, required 1 3 a5a5a5a5", bus.bram_wen, bus.bram_waddr, bus.bram_din);
        end
        drive(1'b0, 2'b01, 2'b00, 5'd3, '0, '0, '0);
        tests++; if (bus.req_ready !== 2'b01 || bus.bram_raddr !== 5'd3 || bus.bram_wen !== 1'b0) begin
            fails++; $display("FAIL rd_port: got ready %b raddr %0d wen %b, required 01 3 0", bus.req_ready, bus.bram_raddr, bus.bram_wen);
        end
        expect_rsp(1'b0, 32'hA5A5_A5A5);
        idle();
    endtask

    task automatic test_mixed();
        drive(1'b0, 2'b11, 2'b01, 5'd1, 5'd2, 32'h1111_1111, '0);
        tests++; if (bus.req_ready !== 2'b11) begin fails++; $display("FAIL mixed_ready: got %b, required 11", bus.req_ready); end
        tests++; if (bus.bram_waddr !== 5'd1 || bus.bram_din !== 32'h1111_1111 || bus.bram_raddr !== 5'd2) begin
            fails++; $display("FAIL mixed_port: got waddr %0d din %h raddr %0d, required 1 11111111 2", bus.bram_waddr, bus.bram_din, bus.bram_raddr);
        end
        expect_rsp(1'b1, 32'h0);
        idle();
        tests++; if (conflict_cnt !== 16'(cnt_exp)) begin fails++; $display("FAIL mixed_cnt: got %0d, required %0d", conflict_cnt, cnt_exp); end
    endtask

    task automatic test_read_contention();
        for (int i = 0; i < 4; i++) begin
            logic w;
            w = RR ? logic'(i % 2) : 1'b0;
            drive(1'b0, 2'b11, 2'b00, 5'd3, 5'd1, '0, '0);
            tests++; if (bus.req_ready !== (w ? 2'b10 : 2'b01) || bus.bram_raddr !== (w ? 5'd1 : 5'd3)) begin
                fails++; $display("FAIL rd_cont_%0d: got ready %b raddr %0d, required winner r%0d", i, bus.req_ready, bus.bram_raddr, w);
            end
            expect_rsp(w, w ? 32'h1111_1111 : 32'hA5A5_A5A5);
        end
        idle();
        cnt_exp += 4;
        tests++; if (conflict_cnt !== 16'(cnt_exp)) begin fails++; $display("FAIL rd_cont_cnt: got %0d, required %0d", conflict_cnt, cnt_exp); end
    endtask

    task automatic test_write_contention();
        for (int i = 0; i < 2; i++) begin
            logic w;
            logic [DLEN-1:0] d0, d1;
            w  = RR ? logic'(i % 2) : 1'b0;
            d0 = 32'h7000_0000 + 32'(i);
            d1 = 32'h7100_0000 + 32'(i);
            drive(1'b0, 2'b11, 2'b11, 5'd7, 5'd7, d0, d1);
            tests++; if (bus.req_ready !== (w ? 2'b10 : 2'b01) || bus.bram_din !== (w ? d1 : d0)) begin
                fails++; $display("FAIL wr_cont_%0d: got ready %b din %h, required winner r%0d", i, bus.req_ready, bus.bram_din, w);
            end
            exp7 = w ? d1 : d0;
        end
        cnt_exp += 2;
        drive(1'b0, 2'b01, 2'b00, 5'd7, '0, '0, '0);
        expect_rsp(1'b0, exp7);
        idle();
    endtask

    task automatic test_read_before_write();
        drive(1'b0, 2'b01, 2'b01, 5'd5, '0, 32'h1, '0);
        drive(1'b0, 2'b11, 2'b01, 5'd5, 5'd5, 32'h2, '0);
        tests++; if (bus.req_ready !== 2'b11) begin fails++; $display("FAIL rbw_ready: got %b, required 11", bus.req_ready); end
        expect_rsp(1'b1, 32'h1);
        drive(1'b0, 2'b10, 2'b00, '0, 5'd5, '0, '0);
        expect_rsp(1'b1, 32'h2);
        idle();
    endtask

    task automatic test_back_to_back();
        logic [HLEN-1:0] addrs [4];
        logic [DLEN-1:0] datas [4];
        addrs = '{5'd1, 5'd3, 5'd5, 5'd7};
        datas = '{32'h1111_1111, 32'hA5A5_A5A5, 32'h2, exp7};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b10, 2'b00, '0, addrs[i], '0, '0);
            tests++; if (bus.req_ready !== 2'b10) begin fails++; $display("FAIL b2b_ready_%0d: got %b, required 10", i, bus.req_ready); end
            expect_rsp(1'b1, datas[i]);
        end
        idle();
        tests++; if (conflict_cnt !== 16'(cnt_exp)) begin fails++; $display("FAIL b2b_cnt: got %0d, required %0d", conflict_cnt, cnt_exp); end
    endtask

    task automatic test_reset_during_read();
        drive(1'b0, 2'b11, 2'b00, 5'd3, 5'd1, '0, '0);
        tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL rdr_pre_ready: got %b, required 01", bus.req_ready); end
        expect_rsp(1'b0, 32'hA5A5_A5A5);
        drive(1'b0, 2'b10, 2'b00, '0, 5'd1, '0, '0);
        tests++; if (bus.req_ready !== 2'b10) begin fails++; $display("FAIL rdr_grant: got %b, required 10", bus.req_ready); end
        drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
        tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL rdr_dropped: got %b, required 00", bus.rsp_valid); end
        cnt_exp = 0;
        drive(1'b0, 2'b11, 2'b00, 5'd3, 5'd1, '0, '0);
        tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL rdr_ptr_reset: got %b, required 01", bus.req_ready); end
        tests++; if (conflict_cnt !== 16'd0) begin fails++; $display("FAIL rdr_cnt_reset: got %0d, required 0", conflict_cnt); end
        tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL rdr_post_rsp: got %b, required 00", bus.rsp_valid); end
        expect_rsp(1'b0, 32'hA5A5_A5A5);
        cnt_exp = 1;
        idle();
        tests++; if (conflict_cnt !== 16'd1) begin fails++; $display("FAIL rdr_cnt_one: got %0d, required 1", conflict_cnt); end
    endtask

    task automatic test_saturation();
        int unsigned start;
        start = cnt_exp;
        for (int i = 0; i < 65540; i++) begin
            drive(1'b0, 2'b11, 2'b11, '0, '0, 32'(i), 32'(i));
            if (i == 100 || i == 65533 || i == 65534 || i == 65539) begin
                int unsigned e;
                e = (start + i > 32'hFFFF) ? 32'hFFFF : start + i;
                tests++; if (conflict_cnt !== 16'(e)) begin fails++; $display("FAIL sat_%0d: got %h, required %h", i, conflict_cnt, e); end
            end
        end
        idle();
        tests++; if (conflict_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: got %h, required ffff", conflict_cnt); end
        idle();
        tests++; if (conflict_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_idle: got %h, required ffff", conflict_cnt); end
    endtask

    initial begin
        for (int i = 0; i < (1 << HLEN); i++) mem[i] = '0;
        bus.bram_dout = '0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_write_read();
        test_mixed();
        test_read_contention();
        test_write_contention();
        test_read_before_write();
        test_back_to_back();
        test_reset_during_read();
        test_saturation();
        idle();
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL sb_empty: got %0d pending, required 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
